mem_cmd_arbiter: RTL and testbench
==================================

MEM_CMD_ARBITER -- requirements
Module: mem_cmd_arbiter

Interface
REQ-001 STARVE_LIMIT, default 4, maximum consecutive read grants while a write request is eligible.
REQ-002 clk  input  1  system clock; all logic in this single domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_calib_done  input  1  memory calibration complete, asynchronous to clk.
REQ-005 rd_req  input  1  display prefetch requests a read burst; held until rd_ack.
REQ-006 rd_addr  input  30  read byte address.
REQ-007 rd_bl  input  6  read burst length minus one.
REQ-008 rd_urgent  input  1  display FIFO below low-water mark.
REQ-009 rd_ack  output  1  one-cycle pulse: read command issued.
REQ-010 wr_req  input  1  pixel engine requests a write burst; held until wr_ack.
REQ-011 wr_addr  input  30  write byte address.
REQ-012 wr_bl  input  6  write burst length minus one.
REQ-013 wr_data_count  input  7  words currently in memory write-data FIFO.
REQ-014 wr_ack  output  1  one-cycle pulse: write command issued.
REQ-015 cmd_full  input  1  memory command FIFO full.
REQ-016 cmd_instr  output  3  command: 3'b001 read, 3'b000 write.
REQ-017 cmd_bl  output  6  burst length minus one.
REQ-018 cmd_byte_addr  output  30  command byte address.
REQ-019 cmd_en  output  1  command strobe.
REQ-020 busy  output  1  high in ISSUE or GAP.

Function
REQ-021 mem_calib_done passes a two-flop synchronizer (calib_s) before use.
REQ-022 States: WAIT_CAL, IDLE, ISSUE, GAP; WAIT_CAL->IDLE when calib_s=1.
REQ-023 Eligibility: read = rd_req; write = wr_req and wr_data_count >= wr_bl+1 (7-bit compare, no overflow).
REQ-024 IDLE with cmd_full=1 or nothing eligible: stay IDLE, no grant.
REQ-025 Single eligible requester in IDLE: grant it.
REQ-026 Both eligible: starve_cnt >= STARVE_LIMIT -> write; else rd_urgent=1 -> read; else the requester not granted last time (round-robin; last-grant flag resets to write, so read wins first tie).
REQ-027 On grant: register cmd_instr, cmd_bl, cmd_byte_addr ({addr[29:2],2'b00}), assert cmd_en and matching ack, go to ISSUE.
REQ-028 cmd_en and ack high exactly the one cycle spent in ISSUE; cmd_instr/bl/addr stable through ISSUE and GAP.
REQ-029 ISSUE->GAP->IDLE unconditionally; minimum 3 cycles between successive cmd_en pulses.
REQ-030 Requester drops req the cycle after ack; a req still high in IDLE is a new request.
REQ-031 starve_cnt: increments (saturating at STARVE_LIMIT) on each read grant while write eligible; clears on write grant or when write not eligible.
REQ-032 calib_s falling in IDLE -> WAIT_CAL; in ISSUE/GAP the sequence completes, then WAIT_CAL.
REQ-033 Simultaneous grant decision and cmd_full rising in same cycle: cmd_full sampled at decision edge governs; an issued cmd_en is never withdrawn.

Reset
REQ-034 reset=1 immediately forces state WAIT_CAL, cmd_en=0, rd_ack=0, wr_ack=0, busy=0, cmd_instr=3'b000, cmd_bl=0, cmd_byte_addr=0, starve_cnt=0, calib sync flops=0, last-grant=write.
REQ-035 Reset mid-ISSUE drops cmd_en asynchronously; after release, calib_s requires two clk edges before leaving WAIT_CAL.

Verification
REQ-036 calib_done high, rd_req, rd_addr=0x103, rd_bl=63 -> one cmd_en, cmd_instr=001, cmd_byte_addr=0x100, cmd_bl=63, rd_ack same cycle.
REQ-037 wr_req, wr_bl=31, wr_data_count=31 -> no grant; wr_data_count=32 -> write issued, cmd_instr=000.
REQ-038 Both eligible continuously, rd_urgent=1, STARVE_LIMIT=4 -> grant order R,R,R,R,W,R...; both eligible, rd_urgent=0 -> R,W,R,W.
REQ-039 cmd_full=1 with rd_req pending for 10 cycles -> no cmd_en; cmd_full=0 -> read issued on next decision.
REQ-040 Reset asserted during ISSUE -> cmd_en and rd_ack 0 immediately; no command until calib_s re-synchronized.
REQ-041 mem_calib_done dropped during GAP -> GAP completes, WAIT_CAL, no further cmd_en until calib returns.

Source files
------------

// File: rtl/mem_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mem_cmd_arbiter
//  Description : Arbitrates display-prefetch reads and pixel-engine writes onto
//                a single memory command port. It holds off until memory
//                calibration completes, prevents write starvation, and leaves a
//                fixed three-cycle spacing between command strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_calib_done,
   input  logic        rd_req,
   input  logic [29:0] rd_addr,
   input  logic [5:0]  rd_bl,
   input  logic        rd_urgent,
   output logic        rd_ack,
   input  logic        wr_req,
   input  logic [29:0] wr_addr,
   input  logic [5:0]  wr_bl,
   input  logic [6:0]  wr_data_count,
   output logic        wr_ack,
   input  logic        cmd_full,
   output logic [2:0]  cmd_instr,
   output logic [5:0]  cmd_bl,
   output logic [29:0] cmd_byte_addr,
   output logic        cmd_en,
   output logic        busy
);

   localparam int              c_SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);
   localparam logic [2:0]      c_INSTR_RD = 3'b001;
   localparam logic [2:0]      c_INSTR_WR = 3'b000;

   typedef enum logic [1:0] {
      ST_WAIT_CAL = 2'd0,
      ST_IDLE     = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_calib_meta;
   logic              r_calib_s;
   logic [c_SW-1:0]   r_starve;
   logic              r_last_wr;
   logic              r_cmd_en;
   logic              r_rd_ack;
   logic              r_wr_ack;
   logic [2:0]        r_cmd_instr;
   logic [5:0]        r_cmd_bl;
   logic [29:0]       r_cmd_addr;

   logic [6:0]        w_wr_need;
   logic              w_rd_elig;
   logic              w_wr_elig;
   logic              w_pick_wr;
   logic              w_grant;
   logic [29:0]       w_sel_addr;

   // Bring the asynchronous calibration flag into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_calib_meta <= 1'b0;
         r_calib_s    <= 1'b0;
      end else begin
         r_calib_meta <= mem_calib_done;
         r_calib_s    <= r_calib_meta;
      end
   end

   // A write is only worth issuing once all of its data is already queued;
   // the 7-bit sum keeps bl=63 (64 words) from wrapping.
   assign w_wr_need = {1'b0, wr_bl} + 7'd1;
   assign w_wr_elig = wr_req && (wr_data_count >= w_wr_need);
   assign w_rd_elig = rd_req;
   assign w_grant   = (r_state == ST_IDLE) && r_calib_s && !cmd_full &&
                      (w_rd_elig || w_wr_elig);

   // Pick the winner: starvation guard first, then urgency, then round-robin.
   always_comb begin
      w_pick_wr = 1'b0;
      if (w_wr_elig && !w_rd_elig) begin
         w_pick_wr = 1'b1;
      end else if (w_wr_elig && w_rd_elig) begin
         if (r_starve >= c_LIMIT) begin
            w_pick_wr = 1'b1;
         end else if (rd_urgent) begin
            w_pick_wr = 1'b0;
         end else begin
            w_pick_wr = !r_last_wr;
         end
      end
   end

   // Next-state logic; ISSUE and GAP always run to completion.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_WAIT_CAL: if (r_calib_s) w_next = ST_IDLE;
         ST_IDLE: begin
            if (!r_calib_s) begin
               w_next = ST_WAIT_CAL;
            end else if (w_grant) begin
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE:    w_next = ST_GAP;
         ST_GAP:      w_next = r_calib_s ? ST_IDLE : ST_WAIT_CAL;
         default:     w_next = ST_WAIT_CAL;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_WAIT_CAL;
      end else begin
         r_state <= w_next;
      end
   end

   // Masking the low bits word-aligns the address while still consuming them.
   assign w_sel_addr = (w_pick_wr ? wr_addr : rd_addr) & ~30'd3;

   // Capture the granted command; strobe and ack live for the ISSUE cycle only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmd_en    <= 1'b0;
         r_rd_ack    <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_cmd_instr <= 3'b000;
         r_cmd_bl    <= 6'd0;
         r_cmd_addr  <= 30'd0;
         r_last_wr   <= 1'b1;
      end else begin
         r_cmd_en <= w_grant;
         r_rd_ack <= w_grant && !w_pick_wr;
         r_wr_ack <= w_grant && w_pick_wr;
         if (w_grant) begin
            r_cmd_instr <= w_pick_wr ? c_INSTR_WR : c_INSTR_RD;
            r_cmd_bl    <= w_pick_wr ? wr_bl : rd_bl;
            r_cmd_addr  <= w_sel_addr;
            r_last_wr   <= w_pick_wr;
         end
      end
   end

   // Count reads granted past a waiting write; saturates at the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve <= '0;
      end else if (!w_wr_elig || (w_grant && w_pick_wr)) begin
         r_starve <= '0;
      end else if (w_grant && !w_pick_wr && (r_starve < c_LIMIT)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   assign cmd_en        = r_cmd_en;
   assign rd_ack        = r_rd_ack;
   assign wr_ack        = r_wr_ack;
   assign cmd_instr     = r_cmd_instr;
   assign cmd_bl        = r_cmd_bl;
   assign cmd_byte_addr = r_cmd_addr;
   assign busy          = (r_state == ST_ISSUE) || (r_state == ST_GAP);

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_cmd_arbiter
//  Description : Directed self-checking bench for mem_cmd_arbiter; expected
//                commands are queued as stimulus is applied and matched
//                against each cmd_en strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_arbiter;

   logic        clk;
   logic        reset;
   logic        mem_calib_done;
   logic        rd_req;
   logic [29:0] rd_addr;
   logic [5:0]  rd_bl;
   logic        rd_urgent;
   logic        rd_ack;
   logic        wr_req;
   logic [29:0] wr_addr;
   logic [5:0]  wr_bl;
   logic [6:0]  wr_data_count;
   logic        wr_ack;
   logic        cmd_full;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic        cmd_en;
   logic        busy;

   typedef struct packed {
      logic [2:0]  instr;
      logic [5:0]  bl;
      logic [29:0] addr;
   } cmd_t;

   cmd_t exp_q[$];
   cmd_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_cmd    = 0;
   int   gap_cnt  = 100;
   int   base;
   int   k;

   localparam logic [2:0] RD = 3'b001;
   localparam logic [2:0] WR = 3'b000;

   mem_cmd_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_calib_done (mem_calib_done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_bl          (rd_bl),
      .rd_urgent      (rd_urgent),
      .rd_ack         (rd_ack),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_bl          (wr_bl),
      .wr_data_count  (wr_data_count),
      .wr_ack         (wr_ack),
      .cmd_full       (cmd_full),
      .cmd_instr      (cmd_instr),
      .cmd_bl         (cmd_bl),
      .cmd_byte_addr  (cmd_byte_addr),
      .cmd_en         (cmd_en),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] i, input logic [5:0] bl, input logic [29:0] a);
      cmd_t c;
      c.instr = i;
      c.bl    = bl;
      c.addr  = a;
      exp_q.push_back(c);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until every queued command has been observed.
   task automatic drain(input string tag, input int budget);
      int j;
      j = 0;
      while (exp_q.size() != 0 && j < budget) begin
         @(negedge clk);
         #1;
         j++;
      end
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Scoreboard: every strobe must match the oldest expected command.
   always @(negedge clk) begin
      if (reset) begin
         gap_cnt = 100;
      end else if (cmd_en === 1'b1) begin
         n_cmd++;
         if (exp_q.size() == 0) begin
            check("unexpected_cmd", {31'd0, cmd_en}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("cmd_instr", cmd_instr, e.instr);
            check("cmd_bl", cmd_bl, e.bl);
            check("cmd_byte_addr", cmd_byte_addr, e.addr);
            check("ack_pair", {rd_ack, wr_ack}, (e.instr == RD) ? 2'b10 : 2'b01);
            check("busy_issue", busy, 1'b1);
            check("cmd_spacing", (gap_cnt >= 2) ? 1 : 0, 1);
         end
         gap_cnt = 0;
      end else begin
         if (rd_ack !== 1'b0 || wr_ack !== 1'b0)
            check("ack_without_cmd", {rd_ack, wr_ack}, 2'b00);
         if (gap_cnt < 100) gap_cnt++;
      end
   end

   initial begin
      reset = 1'b1; mem_calib_done = 1'b0; cmd_full = 1'b0;
      rd_req = 1'b0; rd_addr = '0; rd_bl = '0; rd_urgent = 1'b0;
      wr_req = 1'b0; wr_addr = '0; wr_bl = '0; wr_data_count = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_strobes", {cmd_en, rd_ack, wr_ack, busy}, 4'b0000);
      check("rst_instr", cmd_instr, 3'b000);
      check("rst_bl", cmd_bl, 6'd0);
      check("rst_addr", cmd_byte_addr, 30'd0);
      @(posedge clk); #1 reset = 1'b0;

      // Uncalibrated: a pending read must not be issued
      rd_req = 1'b1; rd_addr = 30'h103; rd_bl = 6'd63;
      tick(8);
      check("no_cmd_uncal", n_cmd, 0);

      // Calibration arrives: single aligned read
      push(RD, 6'd63, 30'h100);
      mem_calib_done = 1'b1;
      drain("rd_first", 12);
      @(posedge clk); #1 rd_req = 1'b0;
      @(negedge clk);
      check("gap_busy", {busy, cmd_en}, 2'b10);
      check("gap_hold_addr", cmd_byte_addr, 30'h100);
      tick(3);

      // Write eligibility boundary (bl=31)
      wr_req = 1'b1; wr_addr = 30'h205; wr_bl = 6'd31; wr_data_count = 7'd31;
      base = n_cmd;
      tick(10);
      check("wr31_short", n_cmd, base);
      push(WR, 6'd31, 30'h204);
      wr_data_count = 7'd32;
      drain("wr31_issue", 6);
      @(posedge clk); #1 wr_req = 1'b0;
      tick(3);

      // Write eligibility boundary (bl=63, needs 64 words)
      wr_req = 1'b1; wr_addr = 30'h3FFF_FFFF; wr_bl = 6'd63; wr_data_count = 7'd63;
      base = n_cmd;
      tick(10);
      check("wr63_short", n_cmd, base);
      push(WR, 6'd63, 30'h3FFF_FFFC);
      wr_data_count = 7'd64;
      drain("wr63_issue", 6);
      @(posedge clk); #1 wr_req = 1'b0;
      tick(3);

      // Round-robin, last grant was a write: R,W,R,W
      rd_addr = 30'h111; rd_bl = 6'd5; wr_addr = 30'h222; wr_bl = 6'd7;
      wr_data_count = 7'd100; rd_urgent = 1'b0;
      push(RD, 6'd5, 30'h110); push(WR, 6'd7, 30'h220);
      push(RD, 6'd5, 30'h110); push(WR, 6'd7, 30'h220);
      rd_req = 1'b1; wr_req = 1'b1;
      drain("rr_order", 40);
      @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b0;
      tick(3);

      // Urgent reads against an eligible write: R,R,R,R,W,R
      rd_urgent = 1'b1;
      for (int i = 0; i < 4; i++) push(RD, 6'd5, 30'h110);
      push(WR, 6'd7, 30'h220);
      push(RD, 6'd5, 30'h110);
      rd_req = 1'b1; wr_req = 1'b1;
      drain("starve_order", 60);
      @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
      tick(3);

      // Command FIFO full holds off a pending read
      cmd_full = 1'b1; rd_req = 1'b1; rd_addr = 30'h33; rd_bl = 6'd2;
      base = n_cmd;
      tick(10);
      check("full_hold", n_cmd, base);
      push(RD, 6'd2, 30'h30);
      cmd_full = 1'b0;
      drain("full_release", 3);
      @(posedge clk); #1 rd_req = 1'b0;
      tick(3);

      // Reset during ISSUE drops strobes at once; resync delay afterwards
      rd_req = 1'b1; rd_addr = 30'h44; rd_bl = 6'd1;
      push(RD, 6'd1, 30'h44);
      k = 0;
      while (cmd_en !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("issue_seen", cmd_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_strobes", {cmd_en, rd_ack, busy}, 3'b000);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      push(RD, 6'd1, 30'h44);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("resync_wait", cmd_en, 1'b0);
      end
      drain("resync_cmd", 3);
      @(posedge clk); #1 rd_req = 1'b0;
      tick(3);

      // Calibration lost in GAP: sequence completes, then nothing issues
      rd_req = 1'b1; rd_addr = 30'h5B; rd_bl = 6'd9;
      push(RD, 6'd9, 30'h58);
      drain("pre_calib_drop", 6);
      @(posedge clk); #1 rd_req = 1'b0; mem_calib_done = 1'b0;
      @(negedge clk);
      check("gap_completes", busy, 1'b1);
      tick(4);
      rd_req = 1'b1;
      base = n_cmd;
      tick(10);
      check("calib_lost_hold", n_cmd, base);
      check("calib_lost_idle", busy, 1'b0);
      push(RD, 6'd9, 30'h58);
      mem_calib_done = 1'b1;
      drain("calib_back", 8);
      @(posedge clk); #1 rd_req = 1'b0;
      tick(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
